// File: rtl/vu_tbus_arb_pkg.sv
// rtl/vu_tbus_arb_pkg.sv - shared state encoding and widths for the VU tri-state bus arbiter
package vu_tbus_arb_pkg;

  localparam int OWNER_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } tbus_state_e;

endpackage

// File: rtl/vu_rr_pick.sv
// rtl/vu_rr_pick.sv - combinational round-robin picker: first set request at or after rr_ptr
module vu_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      rr_ptr,
  output logic [NREQ-1:0] win,
  output logic [2:0]      win_idx,
  output logic            any
);

  int              w_sel;
  logic [NREQ-1:0] w_shift;

  // Scan NREQ slots starting at rr_ptr; the first hit is latched via 'any'.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    w_sel   = 0;
    w_shift = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sel   = (int'(rr_ptr) + i) % NREQ;
      w_shift = req >> w_sel;
      if (!any && w_shift[0]) begin
        any     = 1'b1;
        win     = NREQ'(1) << w_sel;
        win_idx = 3'(w_sel);
      end
    end
  end

endmodule

// File: rtl/vu_tbus_arb.sv
// rtl/vu_tbus_arb.sv - round-robin owner of the shared 16-bit tri-state result bus
module vu_tbus_arb
  import vu_tbus_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAXHOLD = 8
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    last,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    oe,
  output logic [OWNER_W-1:0] owner,
  output logic               bus_busy,
  output logic               turn
);

  localparam logic [3:0] HOLD_MAX = 4'(MAXHOLD - 1);

  tbus_state_e        r_state, w_state_nxt;
  logic [2:0]         r_rr_ptr, w_rr_ptr_nxt;
  logic [3:0]         r_hold, w_hold_nxt;
  logic [NREQ-1:0]    r_grant, r_oe, w_oe_nxt;
  logic [OWNER_W-1:0] r_owner, w_owner_nxt;
  logic [NREQ-1:0]    w_win;
  logic [2:0]         w_win_idx;
  logic               w_any;
  logic               w_release;

  vu_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .rr_ptr  (r_rr_ptr),
    .win     (w_win),
    .win_idx (w_win_idx),
    .any     (w_any)
  );

  // r_oe is one-hot, so masking with it selects the owner's last/req bits.
  assign w_release = (|(last & r_oe)) | ~(|(req & r_oe)) |
                     ((r_hold == HOLD_MAX) & (|(req & ~r_oe)));

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_hold_nxt   = r_hold;
    w_oe_nxt     = r_oe;
    w_owner_nxt  = r_owner;
    case (r_state)
      ST_OWN: begin
        if (w_release) begin
          w_state_nxt = ST_TURN;
          w_oe_nxt    = '0;
        end else if (r_hold != HOLD_MAX) begin
          w_hold_nxt = r_hold + 4'd1;
        end
      end
      default: begin
        if (w_any) begin
          w_state_nxt  = ST_OWN;
          w_oe_nxt     = w_win;
          w_owner_nxt  = w_win_idx;
          w_rr_ptr_nxt = (w_win_idx == 3'(NREQ - 1)) ? 3'd0 : w_win_idx + 3'd1;
          w_hold_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_oe_nxt    = '0;
        end
      end
    endcase
  end

  // grant and oe each get their own flops so the tribuf enables are not decoded from owner.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= 3'd0;
      r_hold   <= 4'd0;
      r_grant  <= '0;
      r_oe     <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_hold   <= w_hold_nxt;
      r_grant  <= w_oe_nxt;
      r_oe     <= w_oe_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

  assign grant    = r_grant;
  assign oe       = r_oe;
  assign owner    = r_owner;
  assign bus_busy = |r_oe;
  assign turn     = (r_state == ST_TURN);

`ifdef VU_ASSERT
  a_oe_onehot: assert property (@(posedge clk) disable iff (!reset_l) $onehot0(r_oe));
  a_oe_bbm: assert property (@(posedge clk) disable iff (!reset_l)
    ((r_oe != '0) && ($past(r_oe) != '0)) |-> (r_oe == $past(r_oe)));
  a_grant_eq_oe: assert property (@(posedge clk) disable iff (!reset_l) (r_grant == r_oe));
`endif

endmodule
